bit_downsample_sync: RTL and testbench
======================================

# bit_downsample_sync

Receive-side counterpart of the transmit bit-repeat upsampler. It accepts a stream of hard-decision samples at SAMPLE_PER_SYMBOL samples per symbol, acquires symbol timing on the first bit transition, and tracks timing drift by nudging its sample counter one position at a time. It emits one decided phy bit per symbol with a valid strobe and an end-of-packet marker. It sits between the GFSK demodulator's sign output and the access-address correlator and de-whitening chain.

## Interface
- SAMPLE_PER_SYMBOL, 8, samples per symbol. Must be a power of two in the range 4..16. The counter width is CNT_W = $clog2(SAMPLE_PER_SYMBOL).
- clk  input  1  system clock, 16 MHz
- rst_n  input  1  reset, asynchronous assert, active-low
- sample_bit  input  1  hard-decision sample
- sample_valid  input  1  sample strobe; any duty cycle, nominally every other clk
- sample_valid_last  input  1  marks the final sample of a packet; qualified by sample_valid
- phy_bit  output  1  decided bit, registered
- bit_valid  output  1  one-cycle strobe per decided bit
- bit_valid_last  output  1  one-cycle end-of-packet strobe
- sync_locked  output  1  high while in TRACK

## Operation
- States:
  - IDLE: waiting for a packet.
  - ACQUIRE: searching for the first transition.
  - TRACK: locked, emitting bits.
- Accepted sample: a cycle with sample_valid=1. sample_valid_last without sample_valid is ignored.
- The prev register holds the last accepted sample. A transition is an accepted sample with sample_bit != prev.
- Index: cnt is the index the current accepted sample occupies, 0..SPS-1. D = SPS/2 is the decision index.
- IDLE: on the first accepted sample, set prev and set the next index to 1, then go to ACQUIRE. No output.
- ACQUIRE: on a transition, that sample becomes index 0 and the next index is 1; go to TRACK. Otherwise keep counting modulo SPS. No bits are emitted.
- TRACK, default: next index = (cnt+1) mod SPS.
- TRACK, transition at cnt=k:
  - k=0 or k=D: no correction.
  - 1 ≤ k < D: late boundary. Retard: the next index is k, i.e. the counter holds.
  - D < k ≤ SPS-1: early boundary. Advance: next index = (k+2) mod SPS.
  - At most one sample of correction per transition.
- Decision, macro absent: on the accepted sample with index D, phy_bit ← sample_bit and bit_valid pulses.
- Decision, macro present: see Configuration.
- End of packet: the accepted sample with sample_valid_last=1 ends the packet.
  - TRACK, decision for the current symbol not yet made: flush. phy_bit ← the last sample, or the majority of the window samples captured so far, with missing entries taken as the last sample. bit_valid and bit_valid_last pulse together.
  - TRACK, decision already made, including when the last sample itself is the decision sample: bit_valid_last pulses. It coincides with bit_valid if the last sample is the decision sample; otherwise it pulses alone.
  - ACQUIRE or IDLE: no strobes.
  - All cases return to IDLE.

## Timing
- All outputs are registered. Reset values: phy_bit=0, bit_valid=0, bit_valid_last=0, sync_locked=0. Internal cnt=0, prev=0, state=IDLE.
- Latency: bit_valid and phy_bit update on the clk edge following the cycle in which the decision sample is accepted, i.e. one cycle.
- bit_valid and bit_valid_last are high for exactly one clk.
- sync_locked rises on the edge following the acquiring transition. It falls on the edge after the last sample is accepted.
- Retard and advance take effect on the next accepted sample. Cycles without sample_valid do not alter state.
- rst_n low mid-packet clears all state immediately. No strobes are produced until a new packet is acquired.

## Configuration
- BIT_DOWNSAMPLE_MAJORITY_EN defined:
  - Window registers capture the samples at indices D-1, D and D+1. On a retarded index, the last write wins.
  - The decision is made on the accepted sample with index D+1: phy_bit ← majority(w[D-1], w[D], w[D+1]).
  - bit_valid follows one cycle later.
- Undefined: single-sample decision at index D. No window registers.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs are 0 within the same cycle and stay 0 until acquisition.
- Aligned preamble: SPS=8, sample_valid every 2nd clk, 8×0 then alternating 8×1 / 8×0 for 10 symbols.
  - sync_locked rises after the first 1 sample.
  - The bit sequence is 1,0,1,0,… with 9 bits.
  - bit_valid spacing is exactly 16 clk.
- Slow transmitter: alternating symbols of 9 samples for 20 symbols → each transition lands at k=1 and is retarded. 19 bits are output, no slips or duplicates.
- Fast transmitter: symbols of 7 samples → each transition lands at k=7 and is advanced. 19 bits, correct alternating values.
- End of packet:
  - Last sample at index 2 → the flush bit equals that sample, with bit_valid=bit_valid_last=1 in the same cycle.
  - Last sample at index 6 → bit_valid_last pulses alone.
  - Both cases return to IDLE and sync_locked drops.
- Glitch: a single inverted sample at index D inside a 1 symbol.
  - With BIT_DOWNSAMPLE_MAJORITY_EN, phy_bit=1.
  - Without it, phy_bit=0.

Source files
------------

// File: rtl/bit_downsample_sync.sv
// Sample-to-bit downsampler with transition-driven symbol timing recovery.
// Optional 3-sample majority decision: define BIT_DOWNSAMPLE_MAJORITY_EN.
module bit_downsample_sync #(
    parameter int SAMPLE_PER_SYMBOL = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_bit,
    input  logic sample_valid,
    input  logic sample_valid_last,
    output logic phy_bit,
    output logic bit_valid,
    output logic bit_valid_last,
    output logic sync_locked
);

    localparam int CNT_W = $clog2(SAMPLE_PER_SYMBOL);
    localparam logic [CNT_W-1:0] D = CNT_W'(SAMPLE_PER_SYMBOL / 2);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
`ifdef BIT_DOWNSAMPLE_MAJORITY_EN
    localparam logic [CNT_W-1:0] DEC = D + ONE;
`else
    localparam logic [CNT_W-1:0] DEC = D;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             prev;
    logic             trans;
    logic             decide;
    logic             phy_nx;
    logic             bv_nx;
    logic             bvl_nx;

    assign trans = sample_bit ^ prev;

`ifdef BIT_DOWNSAMPLE_MAJORITY_EN
    logic w_lo;
    logic w_mid;

    // Window taps at D-1 and D; the D+1 tap is the live sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_lo  <= 1'b0;
            w_mid <= 1'b0;
        end else if (sample_valid && state == TRACK) begin
            if (cnt == D - ONE) w_lo <= sample_bit;
            if (cnt == D) w_mid <= sample_bit;
        end
    end

    assign decide = (w_lo & w_mid) | (w_lo & sample_bit) | (w_mid & sample_bit);
`else
    assign decide = sample_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            prev           <= 1'b0;
            phy_bit        <= 1'b0;
            bit_valid      <= 1'b0;
            bit_valid_last <= 1'b0;
            sync_locked    <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            if (sample_valid) prev <= sample_bit;
            phy_bit        <= phy_nx;
            bit_valid      <= bv_nx;
            bit_valid_last <= bvl_nx;
            sync_locked    <= (state_nx == TRACK);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (sample_valid) begin
            unique case (state)
                IDLE: begin
                    cnt_nx   = ONE;
                    state_nx = sample_valid_last ? IDLE : ACQUIRE;
                end
                ACQUIRE: begin
                    cnt_nx = cnt + ONE;
                    if (sample_valid_last) begin
                        state_nx = IDLE;
                    end else if (trans) begin
                        cnt_nx   = ONE;
                        state_nx = TRACK;
                    end
                end
                TRACK: begin
                    cnt_nx = cnt + ONE;
                    // Nudge at most one sample: hold when late, skip when early.
                    if (trans && cnt != '0 && cnt < D) begin
                        cnt_nx = cnt;
                    end else if (trans && cnt > D) begin
                        cnt_nx = cnt + TWO;
                    end
                    if (sample_valid_last) state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        phy_nx = phy_bit;
        bv_nx  = 1'b0;
        bvl_nx = 1'b0;
        if (sample_valid && state == TRACK) begin
            if (cnt == DEC) begin
                phy_nx = decide;
                bv_nx  = 1'b1;
            end
            if (sample_valid_last) begin
                bvl_nx = 1'b1;
                // Early end: unfilled window slots take the last sample.
                if (cnt < DEC) begin
                    phy_nx = sample_bit;
                    bv_nx  = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_downsample_sync.sv
// Scoreboard bench for bit_downsample_sync: directed sample streams,
// expected strobes queued by stimulus and checked by a monitor.
module tb_bit_downsample_sync;

    logic clk = 1'b0;
    logic rst_n;
    logic sample_bit;
    logic sample_valid;
    logic sample_valid_last;
    logic phy_bit;
    logic bit_valid;
    logic bit_valid_last;
    logic sync_locked;

    always #5 clk = ~clk;

    bit_downsample_sync #(.SAMPLE_PER_SYMBOL(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_bit       (sample_bit),
        .sample_valid     (sample_valid),
        .sample_valid_last(sample_valid_last),
        .phy_bit          (phy_bit),
        .bit_valid        (bit_valid),
        .bit_valid_last   (bit_valid_last),
        .sync_locked      (sync_locked)
    );

    typedef struct packed {
        logic v;
        logic l;
        logic b;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   spacing_on = 0;
    bit   have_prev_bv = 0;
    time  prev_bv = 0;

`ifdef BIT_DOWNSAMPLE_MAJORITY_EN
    localparam logic GLITCH_BIT = 1'b1;
`else
    localparam logic GLITCH_BIT = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic v, input logic l, input logic b);
        exp_t e;
        e.v = v;
        e.l = l;
        e.b = b;
        q.push_back(e);
    endtask

    task automatic expect_alt(input int n);
        for (int i = 0; i < n; i++) expect_ev(1'b1, 1'b0, (i % 2) == 0);
    endtask

    task automatic send(input logic b, input logic last);
        sample_bit        = b;
        sample_valid      = 1'b1;
        sample_valid_last = last;
        @(negedge clk);
        sample_valid      = 1'b0;
        sample_valid_last = 1'b0;
        @(negedge clk);
    endtask

    task automatic sym(input logic b, input int n, input int last_at);
        for (int i = 0; i < n; i++) send(b, i == last_at);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (bit_valid || bit_valid_last)) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got valid=%0b last=%0b bit=%0b, expected none",
                         bit_valid, bit_valid_last, phy_bit);
            end else begin
                e = q.pop_front();
                chk("bit_valid", bit_valid, e.v);
                chk("bit_valid_last", bit_valid_last, e.l);
                if (e.v) chk("phy_bit", phy_bit, e.b);
            end
            if (bit_valid && spacing_on) begin
                if (have_prev_bv) chk("bit_spacing", $time - prev_bv, 160);
                prev_bv      = $time;
                have_prev_bv = 1;
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        sample_bit        = 1'b0;
        sample_valid      = 1'b0;
        sample_valid_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_phy_bit", phy_bit, 0);
        chk("reset_bit_valid", bit_valid, 0);
        chk("reset_bit_valid_last", bit_valid_last, 0);
        chk("reset_sync_locked", sync_locked, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned preamble: 8 zeros then alternating symbols
        expect_alt(9);
        expect_ev(1'b0, 1'b1, 1'b0);
        spacing_on = 1;
        sym(1'b0, 8, -1);
        chk("locked_before_edge", sync_locked, 0);
        send(1'b1, 1'b0);
        chk("locked_after_edge", sync_locked, 1);
        sym(1'b1, 7, -1);
        for (int s = 2; s <= 9; s++) sym(s % 2 == 1, 8, (s == 9) ? 7 : -1);
        spacing_on = 0;
        chk("aligned_unlock", sync_locked, 0);

        // Slow transmitter: 9 samples per symbol
        expect_alt(19);
        expect_ev(1'b0, 1'b1, 1'b0);
        sym(1'b0, 9, -1);
        for (int s = 1; s <= 19; s++) begin
            if (s < 19) sym(s % 2 == 1, 9, -1);
            else sym(1'b1, 8, 7);
        end
        chk("slow_unlock", sync_locked, 0);

        // Fast transmitter: 7 samples per symbol
        expect_alt(19);
        expect_ev(1'b0, 1'b1, 1'b0);
        sym(1'b0, 7, -1);
        for (int s = 1; s <= 19; s++) sym(s % 2 == 1, 7, (s == 19) ? 6 : -1);
        chk("fast_unlock", sync_locked, 0);

        // End of packet at index 2: flush
        expect_ev(1'b1, 1'b0, 1'b1);
        expect_ev(1'b1, 1'b1, 1'b0);
        sym(1'b0, 8, -1);
        sym(1'b1, 8, -1);
        sym(1'b0, 3, 2);
        chk("eop2_unlock", sync_locked, 0);

        // End of packet at index 6: last alone
        expect_ev(1'b1, 1'b0, 1'b1);
        expect_ev(1'b1, 1'b0, 1'b0);
        expect_ev(1'b0, 1'b1, 1'b0);
        sym(1'b0, 8, -1);
        sym(1'b1, 8, -1);
        sym(1'b0, 7, 6);
        chk("eop6_unlock", sync_locked, 0);

        // Glitch at index D inside a 1 symbol
        expect_ev(1'b1, 1'b0, GLITCH_BIT);
        expect_ev(1'b0, 1'b1, 1'b0);
        sym(1'b0, 8, -1);
        sym(1'b1, 4, -1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        chk("glitch_unlock", sync_locked, 0);

        // Reset mid-packet
        expect_ev(1'b1, 1'b0, 1'b1);
        sym(1'b0, 8, -1);
        sym(1'b1, 6, -1);
        chk("pre_reset_locked", sync_locked, 1);
        chk("pre_reset_phy_bit", phy_bit, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_phy_bit", phy_bit, 0);
        chk("async_rst_bit_valid", bit_valid, 0);
        chk("async_rst_bit_valid_last", bit_valid_last, 0);
        chk("async_rst_sync_locked", sync_locked, 0);
        @(negedge clk);
        sym(1'b0, 2, -1);
        rst_n = 1'b1;
        @(negedge clk);
        sym(1'b1, 3, -1);
        chk("post_rst_locked", sync_locked, 0);
        chk("post_rst_phy_bit", phy_bit, 0);
        send(1'b1, 1'b1);
        chk("post_rst_end_locked", sync_locked, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
